// File: rtl/mx_pkg.sv
// Shared types and helpers for the bf16 -> MXINT block converter.
// Holds the bf16 field layout, the E8M0 NaN code and the beats-per-block helper.
package mx_pkg;

    localparam int BF16_MAN_W = 7;
    localparam logic [7:0] E8M0_NAN = 8'hFF;

    typedef struct packed {
        logic                  sign;
        logic [7:0]            exp;
        logic [BF16_MAN_W-1:0] man;
    } bf16_t;

    function automatic int beats_per_block(input int k, input int lanes);
        return k / lanes;
    endfunction

endpackage

// File: rtl/mx_quant_elem.sv
// Quantises one bf16 element against the block's shared exponent.
// Aligns the mantissa, rounds half-to-even, clamps symmetrically and applies the sign.
module mx_quant_elem
    import mx_pkg::*;
#(
    parameter int bit_width = 8
) (
    input  bf16_t                elem_i,
    input  logic [7:0]           max_exp_i,
    output logic [bit_width-1:0] q_o
);

    localparam logic [8:0] MAXV = 9'((1 << (bit_width - 1)) - 1);
    localparam logic [8:0] BIAS = 9'(9 - bit_width);

    logic [8:0]  sh_raw;
    logic [3:0]  sh;
    logic [23:0] val;
    logic        up;
    logic [8:0]  rnd;
    logic [8:0]  mag;

    always_comb begin
        sh_raw = {1'b0, max_exp_i - elem_i.exp} + BIAS;
        sh     = (sh_raw > 9'd15) ? 4'd15 : sh_raw[3:0];
        // Integer part in [23:16], guard at 15, sticky below it.
        val    = {1'b1, elem_i.man, 16'h0000} >> sh;
        up     = val[15] && ((|val[14:0]) || val[16]);
        rnd    = {1'b0, val[23:16]} + {8'h00, up};
        mag    = (rnd > MAXV) ? MAXV : rnd;
        if (elem_i.exp == 8'd0) begin
            mag = '0;
        end
        q_o = elem_i.sign ? -bit_width'(mag) : bit_width'(mag);
    end

endmodule

// File: rtl/stream_bf16tomxi_blk.sv
// Streaming bf16 -> MXINT block converter: collects k elements, emits one block.
// Define MX_SPECIAL_EN to map any e==255 element to an E8M0 NaN block.
module stream_bf16tomxi_blk
    import mx_pkg::*;
#(
    parameter int bit_width = 8,
    parameter int k         = 32,
    parameter int lanes     = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [lanes-1:0][15:0]             i_bf16_vec,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic signed [k-1:0][bit_width-1:0] o_mx_vec,
    output logic [7:0]                         o_mx_exp
);

    localparam int NB = beats_per_block(k, lanes);
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if (k % lanes != 0) begin : g_bad_cfg
        $error("k must be a multiple of lanes");
    end

    typedef enum logic [1:0] {COLLECT, CONVERT, EMIT} state_t;

    state_t                        state_q;
    logic [CW-1:0]                 cnt_q;
    logic [7:0]                    max_q, max_d, beat_max;
    logic [NB-1:0][lanes-1:0][15:0] buf_q;
    logic [k-1:0][bit_width-1:0]   q_w;
    logic                          accept;
    logic                          first;

    assign o_ready = (state_q == COLLECT) && !i_rst;
    assign accept  = i_valid && o_ready;
    assign first   = (cnt_q == '0);

    always_comb begin
        beat_max = '0;
        for (int j = 0; j < lanes; j++) begin
            if (i_bf16_vec[j][14:7] > beat_max) begin
                beat_max = i_bf16_vec[j][14:7];
            end
        end
        // The first beat reseeds so nothing from the previous block leaks in.
        max_d = (first || beat_max > max_q) ? beat_max : max_q;
    end

`ifdef MX_SPECIAL_EN
    logic spec_q, spec_d, spec_hit;

    always_comb begin
        spec_hit = 1'b0;
        for (int j = 0; j < lanes; j++) begin
            spec_hit = spec_hit | (i_bf16_vec[j][14:7] == 8'hFF);
        end
        spec_d = (first ? 1'b0 : spec_q) | spec_hit;
    end
`endif

    for (genvar i = 0; i < k; i++) begin : g_q
        mx_quant_elem #(
            .bit_width(bit_width)
        ) u_q (
            .elem_i   (buf_q[i / lanes][i % lanes]),
            .max_exp_i(max_q),
            .q_o      (q_w[i])
        );
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_q[cnt_q] <= i_bf16_vec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= COLLECT;
            cnt_q    <= '0;
            max_q    <= '0;
            o_valid  <= 1'b0;
            o_mx_vec <= '0;
            o_mx_exp <= '0;
`ifdef MX_SPECIAL_EN
            spec_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        max_q <= max_d;
`ifdef MX_SPECIAL_EN
                        spec_q <= spec_d;
`endif
                        if (cnt_q == CW'(NB - 1)) begin
                            cnt_q   <= '0;
                            state_q <= CONVERT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                CONVERT: begin
                    o_mx_vec <= q_w;
                    o_mx_exp <= max_q;
`ifdef MX_SPECIAL_EN
                    if (spec_q) begin
                        o_mx_vec <= '0;
                        o_mx_exp <= E8M0_NAN;
                    end
`endif
                    o_valid <= 1'b1;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_bf16tomxi_blk.sv
// Directed bench for stream_bf16tomxi_blk at bit_width=8, k=32, lanes=8.
// Block vectors come from a table; stall and mid-block reset are hand-written.
module tb_stream_bf16tomxi_blk;

    logic                  clk;
    logic                  rst;
    logic                  i_valid;
    logic                  o_ready;
    logic [7:0][15:0]      din;
    logic                  o_valid;
    logic                  i_ready;
    logic signed [31:0][7:0] o_vec;
    logic [7:0]            o_exp;

    int errors = 0;
    int checks = 0;

    stream_bf16tomxi_blk #(
        .bit_width(8),
        .k        (32),
        .lanes    (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_bf16_vec(din),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_mx_vec  (o_vec),
        .o_mx_exp  (o_exp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        string             name;
        logic [31:0][15:0] blk;
        logic [7:0]        exp;
        logic [31:0][7:0]  q;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic send_beats(input logic [31:0][15:0] blk,
                              input int nbeats, input string nm);
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            i_valid = 1'b1;
            din     = blk[b*8 +: 8];
            chk({nm, " ready"}, 256'(o_ready), 256'(1));
            @(posedge clk);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic run_block(input logic [31:0][15:0] blk, input string nm);
        send_beats(blk, 4, nm);
        chk({nm, " valid_lat_n"}, 256'(o_valid), 256'(0));
        @(negedge clk);
        chk({nm, " valid_lat_n1"}, 256'(o_valid), 256'(1));
    endtask

    task automatic drain(input string nm);
        @(negedge clk);
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk({nm, " valid_drop"}, 256'(o_valid), 256'(0));
        chk({nm, " ready_back"}, 256'(o_ready), 256'(1));
    endtask

    logic [31:0][15:0] blk_a;
    logic [31:0][15:0] blk_b;
    logic [31:0][7:0]  q64;

    initial begin
        for (int i = 0; i < 32; i++) begin
            blk_a[i] = 16'h3F80;
            blk_b[i] = 16'h4000;
            q64[i]   = 8'd64;
        end

        vecs[0].name = "all_one";
        vecs[0].blk  = blk_a;
        vecs[0].exp  = 8'd127;
        vecs[0].q    = q64;

        vecs[1].name = "clamp";
        vecs[1].blk  = blk_a;
        vecs[1].blk[0] = 16'h3FFF;
        vecs[1].exp  = 8'd127;
        vecs[1].q    = q64;
        vecs[1].q[0] = 8'd127;

        vecs[2].name = "rne_mix";
        vecs[2].blk  = '0;
        vecs[2].blk[0] = 16'h4000;
        vecs[2].blk[1] = 16'h3F80;
        vecs[2].blk[2] = 16'hBF40;
        vecs[2].blk[3] = 16'h3F82;
        vecs[2].blk[4] = 16'h3F86;
        vecs[2].exp  = 8'd128;
        vecs[2].q    = '0;
        vecs[2].q[0] = 8'd64;
        vecs[2].q[1] = 8'd32;
        vecs[2].q[2] = 8'hE8;
        vecs[2].q[3] = 8'd32;
        vecs[2].q[4] = 8'd34;

        vecs[3].name = "all_zero";
        vecs[3].blk  = '0;
        vecs[3].exp  = 8'd0;
        vecs[3].q    = '0;

        vecs[4].name = "special";
        vecs[4].blk  = blk_a;
        vecs[4].blk[5] = 16'h7F80;
        vecs[4].exp  = 8'hFF;
        vecs[4].q    = '0;
`ifndef MX_SPECIAL_EN
        vecs[4].q[5] = 8'd64;
`endif

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        din     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst ready_low", 256'(o_ready), 256'(0));
        rst = 1'b0;
        #1;
        chk("rst valid", 256'(o_valid), 256'(0));
        chk("rst exp", 256'(o_exp), 256'(0));
        chk("rst vec", 256'(o_vec), 256'(0));
        chk("rst ready_after", 256'(o_ready), 256'(1));

        for (int v = 0; v < 5; v++) begin
            run_block(vecs[v].blk, vecs[v].name);
            chk({vecs[v].name, " exp"}, 256'(o_exp), 256'(vecs[v].exp));
            chk({vecs[v].name, " vec"}, 256'(o_vec), 256'(vecs[v].q));
            drain(vecs[v].name);
        end

        // Backpressure: offered beats must not be consumed during EMIT.
        run_block(blk_a, "stall");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_valid = 1'b1;
            din     = blk_b[7:0];
            chk("stall ready", 256'(o_ready), 256'(0));
            chk("stall valid", 256'(o_valid), 256'(1));
            chk("stall exp", 256'(o_exp), 256'(127));
            chk("stall vec", 256'(o_vec), 256'(q64));
        end
        @(negedge clk);
        i_valid = 1'b0;
        drain("stall");
        run_block(vecs[2].blk, "post_stall");
        chk("post_stall exp", 256'(o_exp), 256'(128));
        chk("post_stall vec", 256'(o_vec), 256'(vecs[2].q));
        drain("post_stall");

        // Reset in the middle of a block throws away the partial beats.
        send_beats(blk_b, 2, "midrst");
        rst = 1'b1;
        #1;
        chk("midrst ready", 256'(o_ready), 256'(0));
        @(negedge clk);
        chk("midrst valid", 256'(o_valid), 256'(0));
        chk("midrst exp", 256'(o_exp), 256'(0));
        rst = 1'b0;
        run_block(blk_a, "after_rst");
        chk("after_rst exp", 256'(o_exp), 256'(127));
        chk("after_rst vec", 256'(o_vec), 256'(q64));
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
